bram_pattern_tester: RTL and testbench
======================================

// Module: bram_pattern_tester
// PURPOSE
//  Parametrised BRAM self-test engine for the eFPGA user design. Writes a
//  selectable data pattern to every address of one BRAM macro, reads it back,
//  compares each word and reports the error count, the first failing address
//  and a pass flag. It can also run as a continuous soak loop.
//  One instance sits per BRAM; the status outputs drive the io_out pins.
// PARAMETERS
//  ADDR_WIDTH     8            BRAM address width; DEPTH = 2**ADDR_WIDTH
//  DATA_WIDTH     32           Word width; must be 8, 16 or 32
//  RD_LATENCY     1            Clock cycles from rd_addr to valid rd_data (>=1)
//  PRESCALE_WIDTH 16           Width of the prescaler counter and its limit
//  ERR_WIDTH      16           Width of the saturating error counter
//  CFG_WRITE      8'b00010000  bram_config value while in WRITE
//  CFG_READ       8'b00000000  bram_config value in every other state
//  LFSR_SEED      32'hACE1_0001  Seed for mode 3; must be nonzero
// PORTS
//  clk            in   1          Single clock
//  rst            in   1          Synchronous, active-high reset
//  start          in   1          Starts a run; sampled in IDLE only
//  mode           in   2          0 addr-replicate, 1 inverted, 2 walking-one, 3 LFSR
//  continuous     in   1          1: restart WRITE after each READ until rst
//  use_prescaler  in   1          1: advance one address per prescaler tick
//  prescale_limit in   PRESCALE_WIDTH  Tick every prescale_limit+1 cycles
//  inject_err     in   1          Flips bit0 of the word written to addr 0
//  bram_rd_addr   out  ADDR_WIDTH  BRAM read address
//  bram_wr_addr   out  ADDR_WIDTH  BRAM write address
//  bram_wr_data   out  DATA_WIDTH  BRAM write data
//  bram_rd_data   in   DATA_WIDTH  BRAM read data
//  bram_config    out  8          CFG_WRITE or CFG_READ
//  busy           out  1          High in WRITE, READ and DRAIN
//  done           out  1          One-cycle pulse at the end of each READ pass
//  pass           out  1          Sticky: last completed pass had err_count==0
//  err_count      out  ERR_WIDTH  Mismatches since start; saturates at all-ones
//  first_err_addr out  ADDR_WIDTH  Address of the first mismatch since start
//  loop_count     out  16         Completed passes since start; wraps
// BEHAVIOUR
//  Reset: the FSM goes to IDLE. All outputs are 0, except bram_config=CFG_READ.
//  Tick: when use_prescaler=0, tick=1 every cycle. Otherwise tick=1 when
//   prescale==prescale_limit; prescale then wraps to 0. The prescaler is
//   cleared on rst and on entry to WRITE.
//  FSM: IDLE -> WRITE -> READ -> DRAIN -> (DONE) -> IDLE, or -> WRITE if continuous.
//  IDLE: start=1 latches mode, continuous and inject_err. It clears
//   err_count, first_err_addr and loop_count, and enters WRITE next cycle.
//  WRITE: bram_wr_addr=addr and bram_config=CFG_WRITE.
//   Address 0 is presented from the first cycle. addr increments on each tick.
//   Leaving on the tick at addr=DEPTH-1 resets addr to 0 and enters READ.
//  READ: bram_rd_addr=addr and addr increments on each tick. Each tick issues
//   a compare. Exactly RD_LATENCY cycles later, bram_rd_data is compared with
//   the expected word for that address, which travels through an
//   RD_LATENCY-deep address/valid pipeline. The tick at DEPTH-1 enters DRAIN.
//  DRAIN: waits until the compare pipeline is empty (RD_LATENCY cycles).
//   It then pulses done for 1 cycle, updates pass, increments loop_count and
//   goes to IDLE, or to WRITE if continuous.
//  Patterns, with a = address zero-extended:
//   mode0: {a} replicated and truncated to DATA_WIDTH.
//   mode1: ~mode0.
//   mode2: 1 << (a mod DATA_WIDTH).
//   mode3: 32-bit Galois LFSR (taps 0x80200003), low DATA_WIDTH bits. It is
//    reloaded with LFSR_SEED on entry to WRITE and to READ, and steps on the
//    same ticks as addr, so both phases produce an identical sequence.
//  Mismatch: err_count+=1, saturating. first_err_addr is written only while
//   err_count==0. While continuous, errors accumulate across passes.
//  inject_err: applies only to the first WRITE after start.
//  Control inputs: start, mode and continuous are ignored while busy. Only
//   rst aborts a run. rst mid-run drops busy the next cycle, discards
//   in-flight compares and does not pulse done.
//  bram_wr_data is 0 outside WRITE.
// TESTING
//  1 DEPTH=256, no prescaler, mode0, start -> done 1+256+256+RD_LATENCY cycles
//    after start; pass=1, err_count=0.
//  2 Same run with inject_err=1 -> err_count=1, first_err_addr=0, pass=0.
//  3 Bench model corrupts rd_data at addrs 0x37 and 0x80 -> err_count=2,
//    first_err_addr=0x37.
//  4 use_prescaler=1, prescale_limit=9 -> address advances every 10 cycles;
//    all 4 modes pass.
//  5 continuous=1, 3 passes -> loop_count=3, 3 done pulses, no IDLE between passes.
//  6 rst asserted mid-READ -> next cycle busy=0 and outputs at reset values;
//    a new start completes with a pass.

Source files
------------

// File: rtl/bram_pattern_tester.sv
// BRAM self-test engine: writes a pattern to every address of one BRAM,
// reads it back through a latency-matched compare pipe and reports status.
module bram_pattern_tester #(
   parameter int          ADDR_WIDTH     = 8,
   parameter int          DATA_WIDTH     = 32,
   parameter int          RD_LATENCY     = 1,
   parameter int          PRESCALE_WIDTH = 16,
   parameter int          ERR_WIDTH      = 16,
   parameter logic [7:0]  CFG_WRITE      = 8'b0001_0000,
   parameter logic [7:0]  CFG_READ       = 8'b0000_0000,
   parameter logic [31:0] LFSR_SEED      = 32'hACE1_0001
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic                      continuous,
   input  logic                      use_prescaler,
   input  logic [PRESCALE_WIDTH-1:0] prescale_limit,
   input  logic                      inject_err,
   output logic [ADDR_WIDTH-1:0]     bram_rd_addr,
   output logic [ADDR_WIDTH-1:0]     bram_wr_addr,
   output logic [DATA_WIDTH-1:0]     bram_wr_data,
   input  logic [DATA_WIDTH-1:0]     bram_rd_data,
   output logic [7:0]                bram_config,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [ERR_WIDTH-1:0]      err_count,
   output logic [ADDR_WIDTH-1:0]     first_err_addr,
   output logic [15:0]               loop_count
);

   localparam int DSH = $clog2(DATA_WIDTH);
   localparam int REP = (DATA_WIDTH + ADDR_WIDTH - 1) / ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN
   } state_t;

   state_t                    state_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [31:0]               lfsr_q;
   logic [31:0]               lfsr_d;
   logic [PRESCALE_WIDTH-1:0] pre_q;
   logic [PRESCALE_WIDTH-1:0] pre_d;
   logic [1:0]                mode_q;
   logic                      cont_q;
   logic                      inj_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      pass_q;
   logic [7:0]                cfg_q;
   logic [ERR_WIDTH-1:0]      err_q;
   logic [ADDR_WIDTH-1:0]     ferr_q;
   logic [15:0]               loop_q;

   logic                      pv_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0]     pe_q [RD_LATENCY];
   logic [ADDR_WIDTH-1:0]     pa_q [RD_LATENCY];

   logic                      tick;
   logic                      issue;
   logic                      pipe_busy;
   logic                      mismatch;
   logic [DATA_WIDTH-1:0]     pat;
   logic [DATA_WIDTH-1:0]     wr_word;

   function automatic logic [DATA_WIDTH-1:0] pattern(
      input logic [1:0]            m,
      input logic [ADDR_WIDTH-1:0] a,
      input logic [31:0]           l
   );
      logic [DATA_WIDTH-1:0] rep;
      logic [DATA_WIDTH-1:0] p;
      logic [DSH-1:0]        sh;
      rep = DATA_WIDTH'({REP{a}});
      sh  = DSH'(a);
      p   = '0;
      unique case (m)
         2'd0: p = rep;
         2'd1: p = ~rep;
         2'd2: p = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << sh;
         2'd3: p = l[DATA_WIDTH-1:0];
      endcase
      return p;
   endfunction

   assign tick   = !use_prescaler || (pre_q == prescale_limit);
   assign pre_d  = (pre_q == prescale_limit) ? '0
                                             : pre_q + PRESCALE_WIDTH'(1);
   assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
   assign issue  = (state_q == S_READ) && tick;
   assign pat    = pattern(mode_q, addr_q, lfsr_q);

   // Deliberate single-bit corruption of addr 0 on the first write pass
   assign wr_word = pat ^ {{(DATA_WIDTH-1){1'b0}},
                           inj_q && (addr_q == '0)};

   assign mismatch = pv_q[RD_LATENCY-1] &&
                     (bram_rd_data != pe_q[RD_LATENCY-1]);

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         pipe_busy = pipe_busy | pv_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         lfsr_q  <= LFSR_SEED;
         pre_q   <= '0;
         mode_q  <= '0;
         cont_q  <= 1'b0;
         inj_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         cfg_q   <= CFG_READ;
         err_q   <= '0;
         ferr_q  <= '0;
         loop_q  <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pv_q[i] <= 1'b0;
            pe_q[i] <= '0;
            pa_q[i] <= '0;
         end
      end else begin
         done_q  <= 1'b0;
         pre_q   <= pre_d;
         pv_q[0] <= issue;
         pe_q[0] <= pat;
         pa_q[0] <= addr_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pa_q[i] <= pa_q[i-1];
         end

         if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_WIDTH'(1);
            if (err_q == '0) ferr_q <= pa_q[RD_LATENCY-1];
         end

         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  cont_q  <= continuous;
                  inj_q   <= inject_err;
                  err_q   <= '0;
                  ferr_q  <= '0;
                  loop_q  <= '0;
                  state_q <= S_WRITE;
                  busy_q  <= 1'b1;
                  cfg_q   <= CFG_WRITE;
                  addr_q  <= '0;
                  lfsr_q  <= LFSR_SEED;
                  pre_q   <= '0;
               end
            end
            S_WRITE: begin
               if (tick) begin
                  if (addr_q == LAST) begin
                     addr_q  <= '0;
                     lfsr_q  <= LFSR_SEED;
                     inj_q   <= 1'b0;
                     cfg_q   <= CFG_READ;
                     state_q <= S_READ;
                  end else begin
                     addr_q <= addr_q + ADDR_WIDTH'(1);
                     lfsr_q <= lfsr_d;
                  end
               end
            end
            S_READ: begin
               if (tick) begin
                  if (addr_q == LAST) begin
                     addr_q  <= '0;
                     state_q <= S_DRAIN;
                  end else begin
                     addr_q <= addr_q + ADDR_WIDTH'(1);
                     lfsr_q <= lfsr_d;
                  end
               end
            end
            S_DRAIN: begin
               if (!pipe_busy) begin
                  done_q <= 1'b1;
                  pass_q <= (err_q == '0);
                  loop_q <= loop_q + 16'd1;
                  if (cont_q) begin
                     state_q <= S_WRITE;
                     cfg_q   <= CFG_WRITE;
                     addr_q  <= '0;
                     lfsr_q  <= LFSR_SEED;
                     pre_q   <= '0;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

   assign bram_wr_addr   = (state_q == S_WRITE) ? addr_q : '0;
   assign bram_rd_addr   = (state_q == S_READ) ? addr_q : '0;
   assign bram_wr_data   = (state_q == S_WRITE) ? wr_word : '0;
   assign bram_config    = cfg_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign loop_count     = loop_q;

endmodule

// File: tb/tb_bram_pattern_tester.sv
// Directed bench for bram_pattern_tester with a one-cycle-latency BRAM
// model that can corrupt selected read addresses.
module tb_bram_pattern_tester;

   localparam int LIM = 8000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        continuous = 1'b0;
   logic        use_prescaler = 1'b0;
   logic [15:0] prescale_limit = 16'd0;
   logic        inject_err = 1'b0;
   logic [7:0]  bram_rd_addr;
   logic [7:0]  bram_wr_addr;
   logic [31:0] bram_wr_data;
   logic [31:0] bram_rd_data;
   logic [7:0]  bram_config;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] err_count;
   logic [7:0]  first_err_addr;
   logic [15:0] loop_count;

   logic        corrupt = 1'b0;
   logic [31:0] mem [0:255];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   bram_pattern_tester dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode           (mode),
      .continuous     (continuous),
      .use_prescaler  (use_prescaler),
      .prescale_limit (prescale_limit),
      .inject_err     (inject_err),
      .bram_rd_addr   (bram_rd_addr),
      .bram_wr_addr   (bram_wr_addr),
      .bram_wr_data   (bram_wr_data),
      .bram_rd_data   (bram_rd_data),
      .bram_config    (bram_config),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .loop_count     (loop_count)
   );

   always @(posedge clk) begin
      if (bram_config == 8'h10) mem[bram_wr_addr] <= bram_wr_data;
      bram_rd_data <= mem[bram_rd_addr] ^
         ((corrupt && (bram_rd_addr == 8'h37 || bram_rd_addr == 8'h80))
          ? 32'h0000_0001 : 32'h0);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start_run();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < LIM) begin
         @(posedge clk);
         n++;
         #1;
         if (done) break;
      end
      chk("done_seen", {31'b0, done}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] wd [4];
   int n;
   int dones;
   int idles;

   initial begin
      wd[0] = 32'h0101_0101;
      wd[1] = 32'hFEFE_FEFE;
      wd[2] = 32'h0000_0002;
      wd[3] = 32'hD650_8003;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_cfg", {24'b0, bram_config}, 32'h00);
      chk("rst_wdata", bram_wr_data, 32'h0);
      chk("rst_err", {16'b0, err_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // basic run, mode 0
      start_run();
      chk("wr_cfg", {24'b0, bram_config}, 32'h10);
      chk("wr_busy", {31'b0, busy}, 32'd1);
      wait_done(n);
      chk("lat", n, 32'd514);
      chk("p1_pass", {31'b0, pass}, 32'd1);
      chk("p1_err", {16'b0, err_count}, 32'd0);
      chk("p1_loop", {16'b0, loop_count}, 32'd1);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'b0, done}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // injected error at addr 0
      inject_err = 1'b1;
      start_run();
      inject_err = 1'b0;
      wait_done(n);
      chk("inj_err", {16'b0, err_count}, 32'd1);
      chk("inj_first", {24'b0, first_err_addr}, 32'h00);
      chk("inj_pass", {31'b0, pass}, 32'd0);

      // read-side corruption at 0x37 and 0x80
      corrupt = 1'b1;
      start_run();
      wait_done(n);
      corrupt = 1'b0;
      chk("cor_err", {16'b0, err_count}, 32'd2);
      chk("cor_first", {24'b0, first_err_addr}, 32'h37);
      chk("cor_pass", {31'b0, pass}, 32'd0);

      // prescaler, all modes
      use_prescaler = 1'b1;
      prescale_limit = 16'd9;
      for (int m = 0; m < 4; m++) begin
         mode = 2'(m);
         start_run();
         n = 0;
         while (n < 50) begin
            @(posedge clk);
            n++;
            #1;
            if (bram_wr_addr == 8'd1) break;
         end
         chk($sformatf("pre_step%0d", m), n, 32'd10);
         chk($sformatf("pre_wd%0d", m), bram_wr_data, wd[m]);
         wait_done(n);
         chk($sformatf("pre_pass%0d", m), {31'b0, pass}, 32'd1);
         chk($sformatf("pre_err%0d", m), {16'b0, err_count}, 32'd0);
      end
      use_prescaler = 1'b0;
      mode = 2'd0;

      // continuous soak, three passes
      continuous = 1'b1;
      start_run();
      continuous = 1'b0;
      dones = 0;
      idles = 0;
      n = 0;
      while (n < 3 * LIM && dones < 3) begin
         @(posedge clk);
         n++;
         #1;
         if (!busy) idles++;
         if (done) dones++;
      end
      chk("cont_dones", dones, 32'd3);
      chk("cont_loop", {16'b0, loop_count}, 32'd3);
      chk("cont_idle", idles, 32'd0);
      chk("cont_pass", {31'b0, pass}, 32'd1);
      @(posedge clk);
      #1;
      chk("cont_busy", {31'b0, busy}, 32'd1);
      do_reset();
      @(negedge clk);
      rst = 1'b0;

      // reset in the middle of READ
      corrupt = 1'b1;
      start_run();
      repeat (330) @(posedge clk);
      #1;
      chk("mid_rd", {31'b0, bram_rd_addr != 8'd0}, 32'd1);
      chk("mid_err", {16'b0, err_count}, 32'd1);
      do_reset();
      chk("ab_busy", {31'b0, busy}, 32'd0);
      chk("ab_done", {31'b0, done}, 32'd0);
      chk("ab_err", {16'b0, err_count}, 32'd0);
      chk("ab_first", {24'b0, first_err_addr}, 32'd0);
      chk("ab_rd", {24'b0, bram_rd_addr}, 32'd0);
      chk("ab_cfg", {24'b0, bram_config}, 32'h00);
      chk("ab_loop", {16'b0, loop_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      corrupt = 1'b0;
      start_run();
      wait_done(n);
      chk("re_lat", n, 32'd514);
      chk("re_pass", {31'b0, pass}, 32'd1);
      chk("re_loop", {16'b0, loop_count}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
